// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store unit: trunk-size codes, FSM
// state encoding and the lane-index helper.
package mem_pkg;

  localparam logic [1:0] TRUNK_WORD = 2'b00;
  localparam logic [1:0] TRUNK_HALF = 2'b01;
  localparam logic [1:0] TRUNK_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Byte lane L; the half lane is L[1]. With shifting off everything sits in lane 0.
  function automatic logic [1:0] lane_of(input logic [1:0] addr_lo, input logic shift);
    return shift ? addr_lo : 2'b00;
  endfunction

  // Code 11 is treated as a full word.
  function automatic logic is_word_mode(input logic [1:0] mode);
    return (mode != TRUNK_HALF) && (mode != TRUNK_BYTE);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: sign-extended load extract and the
// read-modify-write merge for SH/SB, both driven from the same memory word.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  trunk_mode_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    load_val_o = word_i;
    merged_o   = store_data_i;
    case (trunk_mode_i)
      TRUNK_HALF: begin
        load_val_o = {{16{half_sel[15]}}, half_sel};
        merged_o   = word_i;
        if (lane_i[1]) merged_o[31:16] = store_data_i[15:0];
        else           merged_o[15:0]  = store_data_i[15:0];
      end
      TRUNK_BYTE: begin
        load_val_o = {{24{byte_sel[7]}}, byte_sel};
        merged_o   = word_i;
        case (lane_i)
          2'd1:    merged_o[15:8]  = store_data_i[7:0];
          2'd2:    merged_o[23:16] = store_data_i[7:0];
          2'd3:    merged_o[31:24] = store_data_i[7:0];
          default: merged_o[7:0]   = store_data_i[7:0];
        endcase
      end
      default: begin
        load_val_o = word_i;
        merged_o   = store_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit over a word-only req/ack memory; SH/SB are done
// as read-modify-write. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        trunk_mode,
  input  logic              shift_to_trunk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output state_t            dbg_state
);

  // Handshake: mem_req/mem_we/mem_addr/mem_wdata are held from request until the
  // cycle mem_ack is seen high; the transfer completes on that edge.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  mode_q;
  logic [1:0]  lane_q;
  logic        is_store_q;
  logic [31:0] wdata_q;
  logic [9:0]  cnt_q;
  logic        done_q, err_q, req_q, we_q;
  logic [31:0] load_data_q, mem_wdata_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0] load_val, merged;
  logic        access, trap;

  assign access = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign trap = ((trunk_mode == TRUNK_HALF) && addr[0]) ||
                (is_word_mode(trunk_mode) && (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  lsu_lane_align u_align (
    .word_i       (mem_rdata),
    .trunk_mode_i (mode_q),
    .lane_i       (lane_q),
    .store_data_i (wdata_q),
    .load_val_o   (load_val),
    .merged_o     (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= TRUNK_WORD;
      lane_q      <= 2'b00;
      is_store_q  <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      load_data_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            mode_q     <= trunk_mode;
            lane_q     <= lane_of(addr[1:0], shift_to_trunk);
            is_store_q <= mem_write;
            wdata_q    <= wdata;
            addr_q     <= addr[ADDR_W-1:2];
            cnt_q      <= '0;
            if (trap) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              err_q       <= 1'b1;
              load_data_q <= '0;
            end else if (mem_write && is_word_mode(trunk_mode)) begin
              state_q     <= ST_WR_WAIT;
              req_q       <= 1'b1;
              we_q        <= 1'b1;
              mem_wdata_q <= wdata;
            end else begin
              state_q <= ST_RD_WAIT;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (mem_ack) begin
            if (is_store_q) begin
              state_q     <= ST_WR_WAIT;
              we_q        <= 1'b1;
              mem_wdata_q <= merged;
              cnt_q       <= '0;
            end else begin
              state_q     <= ST_DONE;
              req_q       <= 1'b0;
              done_q      <= 1'b1;
              load_data_q <= load_val;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_DONE;
            req_q       <= 1'b0;
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            load_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_WR_WAIT: begin
          if (mem_ack || (cnt_q == CNT_LAST)) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= !mem_ack;
            if (!mem_ack) load_data_q <= '0;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        default: begin
          // DONE: inputs still belong to the finished instruction, so no accept here.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall     = ((state_q == ST_IDLE) && access) ||
                     (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
  assign load_data = load_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, RMW stores, delayed ack,
// timeout, mid-access reset and the misalign trap when built with it.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, shift_to_trunk = 1'b0;
  logic [1:0]  trunk_mode = 2'b00;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        stall, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_wdata;
  logic [29:0] mem_addr;
  state_t      dbg_state;

  logic        to_stall, to_done, to_err, to_req, to_we;
  logic [31:0] to_load_data, to_wdata;
  logic [29:0] to_addr;
  state_t      to_state;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int snap;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .trunk_mode(trunk_mode), .shift_to_trunk(shift_to_trunk), .addr(addr), .wdata(wdata),
    .stall(stall), .load_data(load_data), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .trunk_mode(trunk_mode), .shift_to_trunk(shift_to_trunk), .addr(addr), .wdata(wdata),
    .stall(to_stall), .load_data(to_load_data), .done(to_done), .err(to_err),
    .mem_req(to_req), .mem_we(to_we), .mem_addr(to_addr), .mem_wdata(to_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(to_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req && mem_we && mem_ack) wr_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    trunk_mode = 2'b00; shift_to_trunk = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    clear_inputs();
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if ({done, err, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {done, err, mem_req, mem_we}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data: got %h want 0", load_data); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
  endtask

  task automatic test_lb;
    do_reset();
    mem_read = 1'b1; trunk_mode = TRUNK_BYTE; shift_to_trunk = 1'b1; addr = 32'h103;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_stall_c1: got %b want 1", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_c1: got %b want 0", mem_req); end
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h80112233;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, stall} !== 3'b101) begin errors++; $display("FAIL lb_rdwait: got %b want 101", {mem_req, mem_we, stall}); end
    checks++; if (mem_addr !== 30'h40) begin errors++; $display("FAIL lb_addr: got %h want 40", mem_addr); end
    tick;
    mem_ack = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({done, err, stall} !== 3'b100) begin errors++; $display("FAIL lb_done: got %b want 100", {done, err, stall}); end
    checks++; if (load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", load_data); end
    tick;
    @(negedge clk);
    checks++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL lb_after: got done=%b st=%0d want 0/0", done, dbg_state); end
  endtask

  task automatic test_sb;
    do_reset();
    snap = wr_cnt;
    mem_write = 1'b1; trunk_mode = TRUNK_BYTE; shift_to_trunk = 1'b1; addr = 32'h101; wdata = 32'hAB;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    checks++; if ({mem_req, mem_we} !== 2'b10) begin errors++; $display("FAIL sb_read_phase: got %b want 10", {mem_req, mem_we}); end
    tick;
    mem_rdata = 32'h0;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, stall} !== 3'b111) begin errors++; $display("FAIL sb_write_phase: got %b want 111", {mem_req, mem_we, stall}); end
    checks++; if (mem_wdata !== 32'h1122AB44) begin errors++; $display("FAIL sb_merge: got %h want 1122ab44", mem_wdata); end
    checks++; if (mem_addr !== 30'h40) begin errors++; $display("FAIL sb_addr: got %h want 40", mem_addr); end
    tick;
    mem_ack = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    checks++; if ({done, err, mem_req} !== 3'b100) begin errors++; $display("FAIL sb_done: got %b want 100", {done, err, mem_req}); end
    tick;
    checks++; if (wr_cnt - snap !== 1) begin errors++; $display("FAIL sb_writes: got %0d want 1", wr_cnt - snap); end
  endtask

  task automatic test_sw_delay;
    do_reset();
    snap = done_cnt;
    mem_write = 1'b1; trunk_mode = TRUNK_WORD; addr = 32'h80; wdata = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, stall, done} !== 4'b1110 || mem_wdata !== 32'hDEADBEEF) begin
        errors++; $display("FAIL sw_hold%0d: got %b/%h want 1110/deadbeef", i, {mem_req, mem_we, stall, done}, mem_wdata);
      end
    end
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL sw_done: got %b want 10", {done, err}); end
    tick; tick; tick;
    checks++; if (done_cnt - snap !== 1) begin errors++; $display("FAIL sw_done_count: got %0d want 1", done_cnt - snap); end
  endtask

  task automatic test_load_variants;
    logic [1:0]  t_mode [6] = '{TRUNK_HALF, TRUNK_HALF, TRUNK_BYTE, 2'b11, TRUNK_WORD, TRUNK_BYTE};
    logic        t_shift[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] t_addr [6] = '{32'h202, 32'h202, 32'h101, 32'h100, 32'h10, 32'h103};
    logic [31:0] t_rdata[6] = '{32'h80017FFF, 32'h80017FFF, 32'h11227F44, 32'hCAFEF00D, 32'h12345678, 32'h112233F0};
    logic [31:0] t_exp  [6] = '{32'hFFFF8001, 32'h00007FFF, 32'h0000007F, 32'hCAFEF00D, 32'h12345678, 32'hFFFFFFF0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_read = 1'b1; trunk_mode = t_mode[i]; shift_to_trunk = t_shift[i]; addr = t_addr[i];
      tick;
      mem_ack = 1'b1; mem_rdata = t_rdata[i];
      tick;
      mem_ack = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || load_data !== t_exp[i]) begin
        errors++; $display("FAIL load%0d: got done=%b err=%b %h want 1/0 %h", i, done, err, load_data, t_exp[i]);
      end
      tick;
    end
  endtask

  task automatic test_rmw_variants;
    logic [1:0]  t_mode [2] = '{TRUNK_HALF, TRUNK_BYTE};
    logic        t_shift[2] = '{1'b1, 1'b0};
    logic [31:0] t_addr [2] = '{32'h202, 32'h103};
    logic [31:0] t_wdata[2] = '{32'h12345678, 32'h00000055};
    logic [31:0] t_exp  [2] = '{32'h5678CCDD, 32'hAABBCC55};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      mem_write = 1'b1; trunk_mode = t_mode[i]; shift_to_trunk = t_shift[i]; addr = t_addr[i]; wdata = t_wdata[i];
      tick;
      mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD;
      tick;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_wdata !== t_exp[i]) begin
        errors++; $display("FAIL rmw%0d: got we=%b %h want 1 %h", i, mem_we, mem_wdata, t_exp[i]);
      end
      tick;
      mem_ack = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmw%0d_done: got %b want 1", i, done); end
      tick;
    end
  endtask

  task automatic test_timeout;
    do_reset();
    mem_read = 1'b1; trunk_mode = TRUNK_WORD; addr = 32'h10;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick;
    mem_ack = 1'b0; mem_read = 1'b0;
    tick;
    // dut_to now holds a nonzero load result; the timed-out load must clear it.
    mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      @(negedge clk);
      checks++;
      if (to_req !== 1'b1 || to_done !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: got req=%b done=%b want 1/0", i, to_req, to_done);
      end
    end
    tick;
    mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({to_done, to_err, to_req} !== 3'b110) begin errors++; $display("FAIL to_done: got %b want 110", {to_done, to_err, to_req}); end
    checks++; if (to_load_data !== 32'h0) begin errors++; $display("FAIL to_load_data: got %h want 0", to_load_data); end
    tick;
    @(negedge clk);
    checks++; if ({to_done, to_err} !== 2'b00) begin errors++; $display("FAIL to_after: got %b want 00", {to_done, to_err}); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    mem_read = 1'b1; trunk_mode = TRUNK_WORD; addr = 32'h20;
    tick;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req: got %b want 1", mem_req); end
    snap = done_cnt;
    tick;
    reset = 1'b1; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    tick;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, done, stall} !== 3'b000) begin errors++; $display("FAIL rm_flags: got %b want 000", {mem_req, done, stall}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_state: got %0d want 0", dbg_state); end
    tick;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (load_data !== 32'h0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_late_ack: got %h st=%0d want 0/0", load_data, dbg_state); end
    tick;
    checks++; if (done_cnt - snap !== 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", done_cnt - snap); end
  endtask

  task automatic test_misalign;
    do_reset();
    mem_read = 1'b1; trunk_mode = TRUNK_HALF; shift_to_trunk = 1'b1; addr = 32'h201;
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    checks++; if ({mem_req, stall} !== 2'b01) begin errors++; $display("FAIL ma_c1: got %b want 01", {mem_req, stall}); end
    tick;
    mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({done, err, mem_req} !== 3'b110) begin errors++; $display("FAIL ma_done: got %b want 110", {done, err, mem_req}); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL ma_data: got %h want 0", load_data); end
    tick;
    @(negedge clk);
    checks++; if ({done, mem_req} !== 2'b00) begin errors++; $display("FAIL ma_after: got %b want 00", {done, mem_req}); end
`else
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h1234ABCD;
    tick;
    mem_ack = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL ma_done: got %b want 10", {done, err}); end
    checks++; if (load_data !== 32'hFFFFABCD) begin errors++; $display("FAIL ma_data: got %h want ffffabcd", load_data); end
    tick;
`endif
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sb();
    test_sw_delay();
    test_load_variants();
    test_rmw_variants();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
